// File: rtl/sat_add_pkg.sv
// Shared helpers for the round-robin saturating adder: clamp limits,
// the signed overflow rule and the round-robin pointer advance.
package sat_add_pkg;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // Overflow only when both operands share a sign and the wrapped sum does not.
    function automatic logic sat_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/sat_add_rr_scheduler_if.sv
// Requester and result bundle of the shared saturating adder; the scheduler
// is the slave, operand producers and the result consumer together are the master.
interface sat_add_rr_scheduler_if #(
    parameter int W       = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [W-1:0]         res_sum;
    logic [ID_W-1:0]      res_id;
    logic                 res_sat;
    logic [CNT_W-1:0]     sat_count;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id, res_sat, sat_count
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id, res_sat, sat_count
    );
endinterface

// File: rtl/sat_add_rr_scheduler_signed_add_sat.sv
// Combinational W-bit signed adder that clamps to the most positive or most
// negative value when the two's complement sum overflows.
module signed_add_sat #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         overflow
);
    import sat_add_pkg::*;

    logic [W-1:0] w_wrap;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        w_wrap   = a + b;
        overflow = sat_overflow(a[W-1], b[W-1], w_wrap[W-1]);
        sum      = w_wrap;
        if (overflow) begin
            sum = a[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
        end
    end
endmodule

// File: rtl/sat_add_rr_scheduler.sv
// Round-robin arbiter sharing one saturating adder between NUM_REQ requesters,
// with a single registered result slot and a sticky count of clamp events.
module sat_add_rr_scheduler #(
    parameter int W       = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sat_add_rr_scheduler_if.slave  bus
);
    import sat_add_pkg::*;

    logic [ID_W-1:0]  r_ptr;
    logic             r_res_valid;
    logic [W-1:0]     r_res_sum;
    logic [ID_W-1:0]  r_res_id;
    logic             r_res_sat;
    logic [CNT_W-1:0] r_sat_count;

    logic [ID_W-1:0]  w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic             w_accept;
    logic             w_xfer;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_sum;
    logic             w_ovf;

    // First valid requester at or after r_ptr, wrapping past the last index.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    assign w_accept = !r_res_valid || bus.res_ready;
    assign w_xfer   = !rst && w_any && w_accept;

    always_comb begin
        bus.req_ready = '0;
        if (w_xfer) begin
            bus.req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_a = bus.req_a[int'(w_gnt)*W +: W];
    assign w_b = bus.req_b[int'(w_gnt)*W +: W];

    signed_add_sat #(.W(W)) u_add (
        .a        (w_a),
        .b        (w_b),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_res_sat   <= 1'b0;
            r_sat_count <= '0;
        end else if (w_xfer) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_id    <= w_gnt;
            r_res_sat   <= w_ovf;
            r_ptr       <= ID_W'(rr_next(int'(w_gnt), NUM_REQ));
            if (w_ovf && (r_sat_count != '1)) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_res_sum;
    assign bus.res_id    = r_res_id;
    assign bus.res_sat   = r_res_sat;
    assign bus.sat_count = r_sat_count;
endmodule
